// File: rtl/exc_pkg.sv
// Shared definitions for the exception controller: ExcCodes, exc_flags bit positions,
// FSM state encoding and the default handler vector.
package exc_pkg;
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int FLG_ADEL_IF = 0;
    localparam int FLG_RI      = 1;
    localparam int FLG_OV      = 2;
    localparam int FLG_SYS     = 3;
    localparam int FLG_BP      = 4;
    localparam int FLG_ADEL_D  = 5;
    localparam int FLG_ADES    = 6;
    localparam int EXC_FLAG_W  = 7;

    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'hBFC0_0380;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } exc_state_e;
endpackage

// File: rtl/irq_sync.sv
// Parametrised multi-flop synchroniser for asynchronous level-sensitive interrupt lines.
module irq_sync #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_q = r_stage[STAGES-1];
endmodule

// File: rtl/exception_ctrl.sv
// Precise exception / interrupt / eret sequencer: IDLE -> FLUSH -> REDIRECT with CP0 update pulses.
// Optional Count/Compare timer interrupt on IP[7] is enabled by macro EXC_CTRL_TIMER_IRQ_EN.
module exception_ctrl
    import exc_pkg::*;
#(
    parameter int          HW_IRQ_NUM  = 6,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] EXC_VECTOR  = DEFAULT_EXC_VECTOR
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [HW_IRQ_NUM-1:0] hw_irq,
    input  logic [1:0]            sw_ip,
    input  logic                  status_ie,
    input  logic                  status_exl,
    input  logic [7:0]            status_im,
    input  logic                  commit_valid,
    input  logic [31:0]           commit_pc,
    input  logic                  commit_ds,
    input  logic [EXC_FLAG_W-1:0] exc_flags,
    input  logic [31:0]           exc_badaddr,
    input  logic                  eret,
    input  logic [31:0]           epc_in,
    output logic                  flush,
    input  logic                  flush_ack,
    output logic                  redirect_valid,
    output logic [31:0]           redirect_pc,
    output logic                  busy,
    output logic                  cp0_we,
    output logic                  cp0_exl_set,
    output logic                  cp0_exl_clr,
    output logic                  cp0_epc_we,
    output logic [31:0]           cp0_epc,
    output logic                  cp0_bva_we,
    output logic [31:0]           cp0_badvaddr,
    output logic [4:0]            cp0_exccode,
    output logic                  cp0_bd,
`ifdef EXC_CTRL_TIMER_IRQ_EN
    input  logic                  count_we,
    input  logic                  compare_we,
    input  logic [31:0]           timer_wdata,
    output logic [31:0]           count_out,
`endif
    output logic [5:0]            cp0_ip_hw
);
    exc_state_e            r_state, w_state_next;
    logic [HW_IRQ_NUM-1:0] w_irq_sync;
    logic [5:0]            w_ip_ext;
    logic                  w_timer_irq;
    logic                  w_pending, w_trigger;
    logic [4:0]            w_code;
    logic [31:0]           w_bva, w_target, w_epc;
    logic                  w_bva_we, w_epc_we, w_eret_clean;

    logic [31:0] r_target, r_epc, r_bva;
    logic [4:0]  r_code;
    logic        r_bd, r_epc_we, r_bva_we, r_eret_clean;

    irq_sync #(.WIDTH(HW_IRQ_NUM), .STAGES(SYNC_STAGES)) u_irq_sync (
        .clk    (clk),
        .resetn (resetn),
        .i_d    (hw_irq),
        .o_q    (w_irq_sync)
    );

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_ip
            if (gi < HW_IRQ_NUM) begin : g_line
                assign w_ip_ext[gi] = w_irq_sync[gi];
            end else begin : g_zero
                assign w_ip_ext[gi] = 1'b0;
            end
        end
    endgenerate

`ifdef EXC_CTRL_TIMER_IRQ_EN
    logic [31:0] r_count, r_compare;
    logic        r_half, r_timer_irq;

    // Count advances on every other cycle; the interrupt fires as it steps onto Compare.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count     <= '0;
            r_compare   <= '0;
            r_half      <= 1'b0;
            r_timer_irq <= 1'b0;
        end else begin
            r_half <= ~r_half;
            if (count_we) r_count <= timer_wdata;
            else if (r_half) r_count <= r_count + 32'd1;
            if (compare_we) begin
                r_compare   <= timer_wdata;
                r_timer_irq <= 1'b0;
            end else if (r_half && !count_we && (r_count + 32'd1 == r_compare)) begin
                r_timer_irq <= 1'b1;
            end
        end
    end

    assign count_out   = r_count;
    assign w_timer_irq = r_timer_irq;
`else
    assign w_timer_irq = 1'b0;
`endif

    assign cp0_ip_hw = {w_ip_ext[5] | w_timer_irq, w_ip_ext[4:0]};
    assign w_pending = (|({cp0_ip_hw, sw_ip} & status_im)) & status_ie & ~status_exl;
    assign w_trigger = (r_state == ST_IDLE) & commit_valid & (w_pending | (|exc_flags) | eret);
    assign w_epc     = commit_ds ? commit_pc - 32'd4 : commit_pc;

    // Cause resolution; the final branches are only reachable through eret.
    always_comb begin
        w_code       = EXC_INT;
        w_bva        = '0;
        w_bva_we     = 1'b0;
        w_epc_we     = ~status_exl;
        w_target     = EXC_VECTOR;
        w_eret_clean = 1'b0;
        if (w_pending) begin
            w_code = EXC_INT;
        end else if (exc_flags[FLG_ADEL_IF]) begin
            w_code   = EXC_ADEL;
            w_bva    = commit_pc;
            w_bva_we = 1'b1;
        end else if (exc_flags[FLG_RI]) begin
            w_code = EXC_RI;
        end else if (exc_flags[FLG_OV]) begin
            w_code = EXC_OV;
        end else if (exc_flags[FLG_SYS]) begin
            w_code = EXC_SYS;
        end else if (exc_flags[FLG_BP]) begin
            w_code = EXC_BP;
        end else if (exc_flags[FLG_ADEL_D]) begin
            w_code   = EXC_ADEL;
            w_bva    = exc_badaddr;
            w_bva_we = 1'b1;
        end else if (exc_flags[FLG_ADES]) begin
            w_code   = EXC_ADES;
            w_bva    = exc_badaddr;
            w_bva_we = 1'b1;
        end else if (epc_in[1:0] != 2'b00) begin
            w_code   = EXC_ADEL;
            w_bva    = epc_in;
            w_bva_we = 1'b1;
            w_epc_we = 1'b0;
        end else begin
            w_eret_clean = 1'b1;
            w_epc_we     = 1'b0;
            w_target     = epc_in;
        end
    end

    // Fields that will not be written to CP0 keep their previous value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_target     <= '0;
            r_epc        <= '0;
            r_bva        <= '0;
            r_code       <= '0;
            r_bd         <= 1'b0;
            r_epc_we     <= 1'b0;
            r_bva_we     <= 1'b0;
            r_eret_clean <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_trigger) begin
                r_target     <= w_target;
                r_epc_we     <= w_epc_we;
                r_bva_we     <= w_bva_we;
                r_eret_clean <= w_eret_clean;
                if (!w_eret_clean) r_code <= w_code;
                if (w_epc_we) begin
                    r_epc <= w_epc;
                    r_bd  <= commit_ds;
                end
                if (w_bva_we) r_bva <= w_bva;
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        cp0_we         = 1'b0;
        cp0_exl_set    = 1'b0;
        cp0_exl_clr    = 1'b0;
        cp0_epc_we     = 1'b0;
        cp0_bva_we     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_trigger) w_state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                flush = 1'b1;
                if (flush_ack) w_state_next = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                redirect_valid = 1'b1;
                cp0_we         = 1'b1;
                cp0_exl_set    = ~r_eret_clean;
                cp0_exl_clr    = r_eret_clean;
                cp0_epc_we     = r_epc_we;
                cp0_bva_we     = r_bva_we;
                w_state_next   = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign busy         = (r_state != ST_IDLE);
    assign redirect_pc  = r_target;
    assign cp0_epc      = r_epc;
    assign cp0_badvaddr = r_bva;
    assign cp0_exccode  = r_code;
    assign cp0_bd       = r_bd;
endmodule
